// File: rtl/imul_share_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier among p_num_reqs requesters.
// The optional perf counters are compiled in when IMUL_SHARE_ARBITER_PERF_EN is defined.
module imul_share_arbiter #(
    parameter int p_num_reqs   = 4,
    parameter int p_req_nbits  = 64,
    parameter int p_resp_nbits = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [p_num_reqs-1:0]            req_val,
    output logic [p_num_reqs-1:0]            req_rdy,
    input  logic [p_num_reqs*p_req_nbits-1:0] req_msg,
    output logic [p_num_reqs-1:0]            resp_val,
    input  logic [p_num_reqs-1:0]            resp_rdy,
    output logic [p_resp_nbits-1:0]          resp_msg,
    output logic                             imul_req_val,
    input  logic                             imul_req_rdy,
    output logic [p_req_nbits-1:0]           imul_req_msg,
    input  logic                             imul_resp_val,
    output logic                             imul_resp_rdy,
    input  logic [p_resp_nbits-1:0]          imul_resp_msg
`ifdef IMUL_SHARE_ARBITER_PERF_EN
    ,
    output logic [31:0]                      perf_xact_count,
    output logic [31:0]                      perf_stall_count
`endif
);

    localparam int PTR_W = $clog2(p_num_reqs);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e           state_q;
    logic [PTR_W-1:0] ptr_q, owner_q, locked_grant_q;
    logic             lock_q;

    logic [PTR_W-1:0] rr_grant, grant, ptr_d;
    logic             any_req, is_idle, is_busy, req_fire, resp_fire;

    assign any_req = |req_val;
    assign is_idle = reset && (state_q == IDLE);
    assign is_busy = reset && (state_q == BUSY);

    // Search ptr, ptr+1, ... with explicit wrap so non-power-of-2 counts work.
    always_comb begin
        logic found;
        int   idx;
        rr_grant = ptr_q;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < p_num_reqs; k++) begin
            idx = (int'(ptr_q) + k) % p_num_reqs;
            if (!found && req_val[idx]) begin
                rr_grant = PTR_W'(idx);
                found    = 1'b1;
            end
        end
    end

    // A stalled offer keeps its grant so the multiplier sees a stable request.
    assign grant = lock_q ? locked_grant_q : rr_grant;
    assign ptr_d = (grant == PTR_W'(p_num_reqs - 1)) ? '0 : grant + PTR_W'(1);

    assign imul_req_val  = is_idle && any_req;
    assign imul_req_msg  = req_msg[int'(grant)*p_req_nbits +: p_req_nbits];
    assign imul_resp_rdy = is_busy && resp_rdy[owner_q];
    assign resp_msg      = imul_resp_msg;

    assign req_fire  = imul_req_val && imul_req_rdy;
    assign resp_fire = imul_resp_val && imul_resp_rdy;

    for (genvar i = 0; i < p_num_reqs; i++) begin : g_port
        assign req_rdy[i]  = imul_req_val && imul_req_rdy && (grant == PTR_W'(i));
        assign resp_val[i] = is_busy && imul_resp_val && (owner_q == PTR_W'(i));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            owner_q        <= '0;
            lock_q         <= 1'b0;
            locked_grant_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_fire) begin
                        owner_q <= grant;
                        ptr_q   <= ptr_d;
                        lock_q  <= 1'b0;
                        state_q <= BUSY;
                    end else if (imul_req_val && !imul_req_rdy) begin
                        lock_q         <= 1'b1;
                        locked_grant_q <= grant;
                    end
                end
                BUSY: begin
                    if (resp_fire) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef IMUL_SHARE_ARBITER_PERF_EN
    logic [31:0] xact_q, stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xact_q  <= '0;
            stall_q <= '0;
        end else begin
            if (req_fire) xact_q <= xact_q + 32'd1;
            if (any_req && !req_fire) stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_xact_count  = xact_q;
    assign perf_stall_count = stall_q;
`endif

    // The multiplier only answers a request it was given.
    a_no_stray_resp: assert property (@(posedge clk) disable iff (!reset)
        (state_q == IDLE) |-> !imul_resp_val);

endmodule
